// File: rtl/regf_mp_if.sv
// Bus between the pipeline (decode read indices, writeback write port)
// and the regf_mp register file.
interface regf_mp_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic            i_clr;
    logic [AW-1:0]   i_raddr0;
    logic [AW-1:0]   i_raddr1;
    logic            i_we;
    logic [AW-1:0]   i_waddr;
    logic [XLEN-1:0] i_wdata;
    logic [XLEN-1:0] o_rdata0;
    logic [XLEN-1:0] o_rdata1;
    logic            o_ready;

    modport master (
        output i_clr, i_raddr0, i_raddr1, i_we, i_waddr, i_wdata,
        input  o_rdata0, o_rdata1, o_ready
    );

    modport slave (
        input  i_clr, i_raddr0, i_raddr1, i_we, i_waddr, i_wdata,
        output o_rdata0, o_rdata1, o_ready
    );
endinterface

// File: rtl/regf_mp.sv
// regf_mp: parametrised integer register file, two async read ports,
// one sync write port, optional bypass and optional hard-wired zero r0.
// A clear sequencer zeroes one entry per cycle after reset or i_clr;
// o_ready is high once the array is valid.
// Optional trace of writes/clears: define REGF_TRACE_EN.
module regf_mp #(
    parameter int XLEN    = 32,
    parameter int NREGS   = 32,
    parameter int AW      = 5,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1
) (
    input logic       i_clk,
    input logic       i_rst_n,
    regf_mp_if.slave  bus
);
    typedef enum logic {CLEAR, READY} state_t;

    localparam logic [AW:0]   NREGS_W = (AW+1)'(NREGS);
    localparam logic [AW-1:0] LAST    = AW'(NREGS - 1);

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] mem [NREGS];
    logic            ready;
    logic            wr_ok;
    logic [AW-1:0]   raddr [2];
    logic [XLEN-1:0] rdata [2];

    assign ready    = (state_q == READY);
    assign raddr[0] = bus.i_raddr0;
    assign raddr[1] = bus.i_raddr1;

    // Accepted write: ready, no clear this cycle (clear wins), index in range, not hard-wired r0
    assign wr_ok = ready && bus.i_we && !bus.i_clr
                 && ({1'b0, bus.i_waddr} < NREGS_W)
                 && !((ZERO_R0 != 0) && (bus.i_waddr == '0));

    // State and clear-counter registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: sweep the array while clearing, leave on i_clr when ready
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CLEAR: begin
                if (cnt_q == LAST) begin
                    state_d = READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            READY: begin
                if (bus.i_clr) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    // Array update: sequencer zero-fill during CLEAR, pipeline writes when ready
    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            if (state_q == CLEAR) begin
                mem[cnt_q] <= '0;
            end else if (wr_ok) begin
                mem[bus.i_waddr] <= bus.i_wdata;
            end
        end
    end

    // Read ports: forced 0 when not ready, out of range or r0; bypass forwards accepted writes
    always_comb begin
        for (int unsigned p = 0; p < 2; p++) begin
            rdata[p] = '0;
            if (ready && ({1'b0, raddr[p]} < NREGS_W)
                && !((ZERO_R0 != 0) && (raddr[p] == '0))) begin
                if ((BYPASS != 0) && wr_ok && (bus.i_waddr == raddr[p])) begin
                    rdata[p] = bus.i_wdata;
                end else begin
                    rdata[p] = mem[raddr[p]];
                end
            end
        end
    end

    assign bus.o_rdata0 = rdata[0];
    assign bus.o_rdata1 = rdata[1];
    assign bus.o_ready  = ready;

`ifdef REGF_TRACE_EN
    // Simulation trace of accepted/dropped writes and clear completion
    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            if (wr_ok) begin
                $display("regf: r[%h]=%h", bus.i_waddr, bus.i_wdata);
            end else if (bus.i_we) begin
                $display("regf: drop r[%h]", bus.i_waddr);
            end
            if ((state_q == CLEAR) && (cnt_q == LAST)) begin
                $display("regf: clear done");
            end
        end
    end
`else
    // Trace disabled: no display logic compiled.
`endif

endmodule
